// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder/controller sharing one full-add cell across a word
//
// Purpose: latches two WIDTH-bit operands on an accepted start, then adds one
// bit per clock (LSB first) through a single full-add cell built from two
// half-add stages and an OR for carry. Result and carry-out are presented
// with a one-cycle done pulse and held until the next accepted start.
//
// Optional feature: define SERIAL_SUB_EN to add the sub input; sub=1 computes
// a-b in two's complement (cout=1 means no borrow).
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous active-high reset, clears all state
//   start in   1      request; sampled only in IDLE or DONE
//   a     in   WIDTH  operand A, captured on the accepted start edge
//   b     in   WIDTH  operand B, captured on the accepted start edge
//   sub   in   1      subtract select (only with SERIAL_SUB_EN)
//   busy  out  1      high while the word is being processed
//   done  out  1      one-cycle pulse when sum/cout are final
//   sum   out  WIDTH  result register
//   cout  out  1      final carry-out
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg_a;
  logic [WIDTH-1:0] shreg_b;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             sub_sel;
  logic             accept;
  logic             last_bit;
  logic             p;
  logic             g1;
  logic             s;
  logic             g2;
  logic             carry_nxt;

`ifdef SERIAL_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // start is only honoured when not mid-word; DONE accepts for back-to-back use
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Full-add cell: two half-add stages, carry is the OR of both generates
  assign p         = shreg_a[0] ^ shreg_b[0];
  assign g1        = shreg_a[0] & shreg_b[0];
  assign s         = p ^ carry;
  assign g2        = p & carry;
  assign carry_nxt = g1 | g2;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_a <= '0;
      shreg_b <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: invert B and seed the carry with 1
      shreg_a <= a;
      shreg_b <= sub_sel ? ~b : b;
      carry   <= sub_sel;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (state == RUN) begin
      carry   <= carry_nxt;
      sum     <= {s, sum[WIDTH-1:1]};
      shreg_a <= {1'b0, shreg_a[WIDTH-1:1]};
      shreg_b <= {1'b0, shreg_b[WIDTH-1:1]};
      cnt     <= cnt + CNT_W'(1);
      if (last_bit) begin
        cout <= carry_nxt;
      end
    end
  end

endmodule
